// File: rtl/vector_result_writer.sv
// Write-back stage for a vector functional unit. It captures one result per clock
// after the unit latency and streams the elements into the vector register file.
module vector_result_writer #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 4,
    parameter int MAXVL   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_i,
    input  logic [6:0]       i_vl,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_we,
    output logic [2:0]       o_wr_vreg,
    output logic [5:0]       o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_chain_valid,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE,
        FINISH
    } state_t;

    localparam logic [6:0] MAX_VL = 7'(MAXVL);
    localparam logic [3:0] LAT    = 4'(LATENCY);

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_next;
    logic [6:0]       elem_cnt;
    logic [6:0]       elem_next;
    logic [6:0]       eff_vl;
    logic [6:0]       vl_next;
    logic [2:0]       vreg;
    logic [2:0]       vreg_next;
    logic             we_next;
    logic             done_next;
    logic [2:0]       wr_vreg_next;
    logic [5:0]       addr_next;
    logic [WIDTH-1:0] data_next;
    logic [6:0]       clamped_vl;

    assign clamped_vl = (i_vl > MAX_VL) ? MAX_VL : i_vl;

    // elem_cnt is one bit wider than the address so that a length of 64 compares
    // exactly; writes are produced the same cycle the matching result is sampled.
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        elem_next    = elem_cnt;
        vl_next      = eff_vl;
        vreg_next    = vreg;
        we_next      = 1'b0;
        done_next    = 1'b0;
        wr_vreg_next = o_wr_vreg;
        addr_next    = o_wr_addr;
        data_next    = o_wr_data;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = WAIT;
                    wait_next  = LAT;
                    vl_next    = clamped_vl;
                    vreg_next  = i_i;
                    elem_next  = 7'd0;
                end
            end

            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    if (eff_vl == 7'd0) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                    end else begin
                        state_next   = WRITE;
                        we_next      = 1'b1;
                        wr_vreg_next = vreg;
                        addr_next    = 6'd0;
                        data_next    = i_result;
                        done_next    = (eff_vl == 7'd1);
                        elem_next    = 7'd1;
                    end
                end else begin
                    wait_next = wait_cnt - 4'd1;
                end
            end

            WRITE: begin
                if (elem_cnt == eff_vl) begin
                    state_next = IDLE;
                end else begin
                    we_next      = 1'b1;
                    wr_vreg_next = vreg;
                    addr_next    = elem_cnt[5:0];
                    data_next    = i_result;
                    done_next    = (elem_cnt == eff_vl - 7'd1);
                    elem_next    = elem_cnt + 7'd1;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            elem_cnt  <= 7'd0;
            eff_vl    <= 7'd0;
            vreg      <= 3'd0;
            o_we      <= 1'b0;
            o_done    <= 1'b0;
            o_wr_vreg <= 3'd0;
            o_wr_addr <= 6'd0;
            o_wr_data <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            elem_cnt  <= elem_next;
            eff_vl    <= vl_next;
            vreg      <= vreg_next;
            o_we      <= we_next;
            o_done    <= done_next;
            o_wr_vreg <= wr_vreg_next;
            o_wr_addr <= addr_next;
            o_wr_data <= data_next;
        end
    end

    assign o_busy        = (state != IDLE);
    assign o_chain_valid = o_we;

endmodule
